// File: rtl/uart_rx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART receive path.
//               Receiver FSM state encoding, parity mode codes, and bit
//               positions of the per-entry error flags.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  // parity_mode encodings; 2'b11 also means no parity
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Bit positions inside the 2-bit error field of a FIFO entry
  localparam int ERR_FRAME  = 1;
  localparam int ERR_PARITY = 0;

  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo_if
// Description : Read-side bus between the UART receive FIFO and the host.
//   rd_en       pop the FIFO head
//   clr_overrun clear the sticky overrun flag
//   rd_data     head data (first-word fall-through)
//   rd_err      head flags, [1] framing, [0] parity
//   rda         FIFO non-empty
//   fifo_count  entries held
//   overrun     sticky, a frame was dropped because the FIFO was full
// Modports    : master = host side, slave = receiver side
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
);
  logic                          rd_en;
  logic                          clr_overrun;
  logic [DATA_BITS-1:0]          rd_data;
  logic [1:0]                    rd_err;
  logic                          rda;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          overrun;

  modport master (
    output rd_en, clr_overrun,
    input  rd_data, rd_err, rda, fifo_count, overrun
  );

  modport slave (
    input  rd_en, clr_overrun,
    output rd_data, rd_err, rda, fifo_count, overrun
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-word-fall-through FIFO.
//   clk, rst   clock, synchronous active-high reset (empties the FIFO)
//   push       write push_data (accepted when not full, or when full and a
//              pop happens in the same cycle)
//   pop        remove the head (ignored when empty)
//   rd_data    current head, valid whenever empty is low
//   count      entries held; full / empty status flags
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_pop;
  logic             w_push;

  assign empty = (r_count == '0);
  assign full  = (r_count == (PTR_W + 1)'(DEPTH));
  assign count = r_count;

  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted when the head leaves at the same edge.
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  // Memory is cleared on reset so the head reads zero before any push.
  assign rd_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : UART receiver with programmable oversampling divisor,
//               optional parity and a FWFT receive FIFO holding data plus
//               framing/parity flags per entry.
//   clk, rst     clock, synchronous active-high reset
//   divisor      clk cycles per oversample tick (0 behaves as 1)
//   parity_mode  00 none, 01 even, 10 odd, 11 none
//   rxd          asynchronous serial input, idle high
//   bus          read-side interface (slave modport)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  divisor,
  input  logic [1:0]        parity_mode,
  input  logic              rxd,
  uart_rx_fifo_if.slave     bus
);
  localparam int SAMP_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W   = $clog2(DATA_BITS + 1);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W = DATA_BITS + 2;

  localparam logic [SAMP_W-1:0] C_HALF_M1  = SAMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMP_W-1:0] C_FULL_M1  = SAMP_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  C_LAST_BIT = BIT_W'(DATA_BITS - 1);

  // Synchroniser and edge history
  logic r_sync1;
  logic r_rxs;
  logic r_rxs_d;

  // Tick generator
  logic [DIV_W-1:0] r_tick_cnt;
  logic [DIV_W-1:0] w_div_m1;
  logic             w_tick;

  // Receiver
  rx_state_t            r_state;
  rx_state_t            w_state_next;
  logic [SAMP_W-1:0]    r_samp_cnt;
  logic [SAMP_W-1:0]    w_samp_target;
  logic                 w_sample;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_err;
  logic                 w_restart;
  logic                 w_push;
  logic [1:0]           w_push_err;
  logic [ENTRY_W-1:0]   w_push_entry;

  // FIFO and status
  logic [ENTRY_W-1:0]   w_head;
  logic [CNT_W-1:0]     w_count;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_drop;
  logic                 r_overrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
      r_rxs_d <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_rxs   <= r_sync1;
      r_rxs_d <= r_rxs;
    end
  end

  // >= rather than == so a divisor reduced below the current count still
  // wraps on the next cycle instead of running round the full counter.
  assign w_div_m1 = (divisor == '0) ? '0 : divisor - DIV_W'(1);
  assign w_tick   = (r_tick_cnt >= w_div_m1);

  always_ff @(posedge clk) begin
    if (rst || w_restart || w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // START samples half a bit after the edge; later states a full bit apart,
  // which lands every later sample on a bit centre.
  assign w_samp_target = (r_state == START) ? C_HALF_M1 : C_FULL_M1;
  assign w_sample      = w_tick && (r_state != IDLE) && (r_samp_cnt == w_samp_target);

  always_ff @(posedge clk) begin
    if (rst || w_restart || w_sample) begin
      r_samp_cnt <= '0;
    end else if (w_tick) begin
      r_samp_cnt <= r_samp_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // IDLE arms only on a 1->0 transition, so a line held low after a bad
  // stop bit produces a single framing-error entry.
  always_comb begin
    w_state_next = r_state;
    w_restart    = 1'b0;
    w_push       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_rxs && r_rxs_d) begin
          w_state_next = START;
          w_restart    = 1'b1;
        end
      end
      START: begin
        if (w_sample) begin
          w_state_next = r_rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (w_sample && (r_bit_cnt == C_LAST_BIT)) begin
          w_state_next = parity_enabled(parity_mode) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (w_sample) begin
          w_state_next = STOP;
        end
      end
      STOP: begin
        if (w_sample) begin
          w_push       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par_err <= 1'b0;
    end else begin
      if (r_state == START) begin
        r_bit_cnt <= '0;
      end else if ((r_state == DATA) && w_sample) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end

      // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
      if ((r_state == DATA) && w_sample) begin
        r_shift <= {r_rxs, r_shift[DATA_BITS-1:1]};
      end

      if (w_restart) begin
        r_par_err <= 1'b0;
      end else if ((r_state == PARITY) && w_sample) begin
        r_par_err <= ((^r_shift) ^ r_rxs) != (parity_mode == PAR_ODD);
      end
    end
  end

  always_comb begin
    w_push_err             = '0;
    w_push_err[ERR_FRAME]  = ~r_rxs;
    w_push_err[ERR_PARITY] = r_par_err;
  end

  assign w_push_entry = {w_push_err, r_shift};

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (bus.rd_en),
    .rd_data   (w_head),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  // Full implies non-empty, so any rd_en this cycle frees a slot.
  assign w_drop = w_push && w_full && !bus.rd_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (bus.clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  assign bus.rd_data    = w_head[DATA_BITS-1:0];
  assign bus.rd_err     = w_head[DATA_BITS +: 2];
  assign bus.rda        = !w_empty;
  assign bus.fifo_count = w_count;
  assign bus.overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Self-checking bench for uart_rx_fifo (8 data bits,
//               16x oversampling, divisor 4, 8-entry FIFO).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;
  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int DIV_W      = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int DIV        = 4;
  localparam int BIT_CYC    = OVERSAMPLE * DIV;

  logic             clk = 1'b0;
  logic             rst;
  logic [DIV_W-1:0] divisor;
  logic [1:0]       parity_mode;
  logic             rxd;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo_if #(.DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  uart_rx_fifo #(
    .DATA_BITS  (DATA_BITS),
    .OVERSAMPLE (OVERSAMPLE),
    .DIV_W      (DIV_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .divisor     (divisor),
    .parity_mode (parity_mode),
    .rxd         (rxd),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] data;
    logic [1:0] mode;
    logic       par_bit;
    logic       stop_bit;
    logic [7:0] exp_data;
    logic [1:0] exp_err;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (BIT_CYC) @(negedge clk);
  endtask

  task automatic send_head(input logic [7:0] d);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic with_par,
                            input logic p, input logic stop);
    send_head(d);
    if (with_par) send_bit(p);
    send_bit(stop);
    rxd = 1'b1;
  endtask

  task automatic pop();
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic wait_rda(input string name, input int budget);
    int n = 0;
    while (!bus.rda && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rda) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic read_check(input string name, input logic [7:0] d, input logic [1:0] e);
    check({name, "_rda"}, bus.rda, 1'b1);
    check({name, "_data"}, bus.rd_data, d);
    check({name, "_err"}, bus.rd_err, e);
    pop();
  endtask

  initial begin
    //            data   mode   par   stop  exp    err
    vecs[0] = '{8'hA5, 2'b00, 1'b0, 1'b1, 8'hA5, 2'b00};
    vecs[1] = '{8'h24, 2'b01, 1'b1, 1'b1, 8'h24, 2'b01};
    vecs[2] = '{8'h24, 2'b01, 1'b0, 1'b1, 8'h24, 2'b00};
    vecs[3] = '{8'h24, 2'b10, 1'b1, 1'b1, 8'h24, 2'b00};
    vecs[4] = '{8'h24, 2'b10, 1'b0, 1'b1, 8'h24, 2'b01};
    vecs[5] = '{8'h3C, 2'b11, 1'b0, 1'b1, 8'h3C, 2'b00};
    vecs[6] = '{8'h55, 2'b00, 1'b0, 1'b0, 8'h55, 2'b10};
    vecs[7] = '{8'hFF, 2'b01, 1'b0, 1'b1, 8'hFF, 2'b00};
    vecs[8] = '{8'h01, 2'b01, 1'b0, 1'b0, 8'h01, 2'b11};

    rst             = 1'b1;
    rxd             = 1'b1;
    divisor         = DIV_W'(DIV);
    parity_mode     = 2'b00;
    bus.rd_en       = 1'b0;
    bus.clr_overrun = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset_rda", bus.rda, 1'b0);
    check("reset_count", bus.fifo_count, 0);
    check("reset_overrun", bus.overrun, 1'b0);
    check("reset_data", bus.rd_data, 0);
    check("reset_err", bus.rd_err, 0);

    // Stop-bit latency: stop centre is half a bit into the stop bit.
    repeat (BIT_CYC) @(negedge clk);
    send_head(8'hA5);
    rxd = 1'b1;
    repeat (BIT_CYC / 2 - 2) @(negedge clk);
    check("t1_rda_before_stop_centre", bus.rda, 1'b0);
    repeat (8) @(negedge clk);
    check("t1_rda_after_stop_centre", bus.rda, 1'b1);
    check("t1_count", bus.fifo_count, 1);
    read_check("t1", 8'hA5, 2'b00);
    check("t1_rda_after_pop", bus.rda, 1'b0);
    repeat (BIT_CYC) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      parity_mode = vecs[i].mode;
      send_frame(vecs[i].data, (vecs[i].mode == 2'b01) || (vecs[i].mode == 2'b10),
                 vecs[i].par_bit, vecs[i].stop_bit);
      wait_rda($sformatf("vec%0d", i), 100);
      check($sformatf("vec%0d_count", i), bus.fifo_count, 1);
      read_check($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_err);
      check($sformatf("vec%0d_empty", i), bus.rda, 1'b0);
      repeat (BIT_CYC) @(negedge clk);
    end
    parity_mode = 2'b00;

    // Back-to-back frames, no idle gap
    send_frame(8'hE7, 1'b0, 1'b0, 1'b1);
    send_frame(8'h24, 1'b0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    check("b2b_count", bus.fifo_count, 2);
    read_check("b2b_first", 8'hE7, 2'b00);
    read_check("b2b_second", 8'h24, 2'b00);

    // Break: bad stop bit then line held low for 20 bit times
    send_head(8'h55);
    rxd = 1'b0;
    repeat (21 * BIT_CYC) @(negedge clk);
    check("break_count", bus.fifo_count, 1);
    read_check("break", 8'h55, 2'b10);
    rxd = 1'b1;
    repeat (2 * BIT_CYC) @(negedge clk);
    check("break_no_extra", bus.fifo_count, 0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    wait_rda("after_break", 100);
    read_check("after_break", 8'h3C, 2'b00);

    // Overrun: nine frames into eight slots
    for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    check("ovr_count", bus.fifo_count, 8);
    check("ovr_flag", bus.overrun, 1'b1);
    for (int i = 0; i < 8; i++) read_check($sformatf("ovr_rd%0d", i), 8'(i), 2'b00);
    check("ovr_flag_sticky", bus.overrun, 1'b1);
    bus.clr_overrun = 1'b1;
    @(negedge clk);
    bus.clr_overrun = 1'b0;
    check("ovr_cleared", bus.overrun, 1'b0);

    // Full FIFO with a pop on the push cycle
    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b0, 1'b1);
    check("full_count", bus.fifo_count, 8);
    send_head(8'h18);
    rxd = 1'b1;
    begin
      int  n = 0;
      bit  hit = 1'b0;
      // dut.w_push only times the rd_en pulse onto the push cycle
      while (!hit && n < BIT_CYC) begin
        if (dut.w_push) begin
          hit = 1'b1;
          pop();
        end else begin
          @(negedge clk);
          n++;
        end
      end
      check("full_push_seen", hit, 1'b1);
    end
    repeat (BIT_CYC) @(negedge clk);
    check("full_pop_no_overrun", bus.overrun, 1'b0);
    check("full_pop_count", bus.fifo_count, 8);
    for (int i = 0; i < 8; i++) read_check($sformatf("full_rd%0d", i), 8'h11 + 8'(i), 2'b00);
    check("full_drained", bus.rda, 1'b0);

    // Glitch of three oversample ticks
    rxd = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * BIT_CYC) @(negedge clk);
    check("glitch_no_entry", bus.fifo_count, 0);

    // Reset mid-frame with one entry already stored
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    check("pre_rst_count", bus.fifo_count, 1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h81 >> i));
    rst = 1'b1;
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rda", bus.rda, 1'b0);
    check("rst_count", bus.fifo_count, 0);
    repeat (6 * BIT_CYC) @(negedge clk);
    check("rst_no_partial", bus.fifo_count, 0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    wait_rda("post_rst", 100);
    read_check("post_rst", 8'h81, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
